ifetch_queue: RTL and testbench

- Instruction-fetch stage directly upstream of the byte-addressed, big-endian instruction ROM.
- Owns the program counter and drives the ROM address each cycle.
- Captures the ROM's same-cycle combinational instruction word into a small FIFO.
- Presents instructions to decode with a valid/ready handshake and supports flush/redirect on branches and jumps.

---
 rtl/ifetch_queue.sv | 113 +++++++++++
 tb/tb_ifetch_queue.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch stage with program counter and small FIFO.
// Drives the ROM address and queues {pc, instr} words for decode.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   rom_pc       byte address to the ROM (equals the pc register)
//   rom_instr    ROM word for rom_pc, valid in the same cycle
//   redirect     branch/jump taken: flush queue, reload pc
//   redirect_pc  redirect target (low two bits ignored)
//   id_ready     decode accepts the head entry
//   if_valid     head entry valid
//   if_instr     head instruction word (0 when empty)
//   if_pc        head instruction address (0 when empty)
//   fetch_oob    pc is past the end of the ROM; fetching stopped
module ifetch_queue #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter int          ROM_BYTES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_pc,
    input  logic [31:0] rom_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_oob
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    if_entry_t     mem [DEPTH];

    logic          oob;
    logic          pop;
    logic          push;
    logic [CW-1:0] count_nxt;
    if_entry_t     head;

    assign oob       = (pc > LAST_PC);
    assign fetch_oob = oob;
    assign rom_pc    = pc;

    assign if_valid = (count != '0);
    assign pop      = if_valid & id_ready;
    assign push     = !redirect & !oob & ((count < FULL) | pop);

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Output mux gated so a stale slot never leaks when the queue is empty.
    assign head     = mem[rd_ptr];
    assign if_instr = if_valid ? head.instr : 32'h0;
    assign if_pc    = if_valid ? head.pc : 32'h0;

    // Control state: redirect overrides both push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
        end
    end

    // Storage is cleared on reset so no old word is ever observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{pc: pc, instr: rom_instr};
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed self-checking bench for ifetch_queue.
// Models the ROM combinationally and checks each step against constants.
module tb_ifetch_queue;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_pc;
    logic [31:0] rom_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_oob;

    int n_cmp = 0;
    int n_err = 0;

    ifetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2),
        .ROM_BYTES(1000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_pc     (rom_pc),
        .rom_instr  (rom_instr),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_ready   (id_ready),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .fetch_oob  (fetch_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h3C02_0003;
            32'd4:   return 32'h0042_1820;
            32'd8:   return 32'h0000_0000;
            default: return 32'hA000_0000 | a;
        endcase
    endfunction

    always_comb rom_instr = rom_word(rom_pc);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic v,
                        input logic [31:0] p, input logic [31:0] rp);
        chk({tag, ".valid"}, 32'(if_valid), 32'(v));
        chk({tag, ".pc"}, if_pc, p);
        chk({tag, ".instr"}, if_instr, v ? rom_word(p) : 32'h0);
        chk({tag, ".rom_pc"}, rom_pc, rp);
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;
        #1;
        head("rst", 1'b0, 32'h0, 32'h0);
        chk("rst.oob", 32'(fetch_oob), 32'h0);
        step();
        rst_n = 1'b1;

        // Streaming from reset with decode always ready.
        step();
        chk("s0.instr_lit", if_instr, 32'h3C02_0003);
        head("s0", 1'b1, 32'd0, 32'd4);
        step();
        head("s1", 1'b1, 32'd4, 32'd8);
        step();
        head("s2", 1'b1, 32'd8, 32'd12);
        id_ready = 1'b0;
        step();
        head("s3", 1'b1, 32'd8, 32'd16);

        // Async reset with two queued entries: effect before any edge.
        #2;
        rst_n = 1'b0;
        #1;
        head("arst", 1'b0, 32'h0, 32'h0);
        step();
        rst_n = 1'b1;

        // Stall: queue saturates at two entries and pc holds.
        repeat (5) step();
        head("stall", 1'b1, 32'd0, 32'd8);
        id_ready = 1'b1;
        step();
        head("drain1", 1'b1, 32'd4, 32'd12);
        step();
        head("drain2", 1'b1, 32'd8, 32'd16);
        step();
        head("full1", 1'b1, 32'd12, 32'd20);
        step();
        head("full2", 1'b1, 32'd16, 32'd24);

        // Redirect with a full queue; low address bits are dropped.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0042;
        step();
        redirect = 1'b0;
        head("redir", 1'b0, 32'h0, 32'h40);
        step();
        head("redir_t", 1'b1, 32'h40, 32'h44);

        // End-of-ROM boundary.
        redirect    = 1'b1;
        redirect_pc = 32'd988;
        id_ready    = 1'b0;
        step();
        redirect = 1'b0;
        head("eor0", 1'b0, 32'h0, 32'd988);
        step();
        step();
        head("eor_full", 1'b1, 32'd988, 32'd996);
        chk("eor_996.oob", 32'(fetch_oob), 32'h0);
        id_ready = 1'b1;
        step();
        head("eor1", 1'b1, 32'd992, 32'd1000);
        chk("eor_1000.oob", 32'(fetch_oob), 32'h1);
        step();
        head("eor2", 1'b1, 32'd996, 32'd1000);
        step();
        head("eor_empty", 1'b0, 32'h0, 32'd1000);
        chk("eor_hold.oob", 32'(fetch_oob), 32'h1);

        // Redirect into range clears oob; out-of-range target sets it.
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        step();
        chk("back.oob", 32'(fetch_oob), 32'h0);
        chk("back.rom_pc", rom_pc, 32'h0);
        redirect_pc = 32'h0000_1000;
        step();
        redirect = 1'b0;
        chk("far.oob", 32'(fetch_oob), 32'h1);
        step();
        head("far_nopush", 1'b0, 32'h0, 32'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
